fmul_wb_queue: RTL and testbench
================================

# fmul_wb_queue

Writeback queue that sits directly downstream of the floating-point multiplier. It captures each completed FMUL result (data plus destination register) in the cycle the multiplier signals completion, and holds it in an in-order FIFO. It drains the FIFO into the register-file write port only in cycles when the main pipeline is not using that port. It also reports pending-write hazards so decode can stall readers of a register whose FMUL result has not yet been written.

## Interface
Parameters:
- DEPTH, 4, number of queue entries; power of two, ≥2
- DATA_W, 32, result width
- ADDR_W, 4, register address width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high reset
- FMULDone  in  1  one-cycle pulse; FMUL result valid this cycle
- FMULResult  in  DATA_W  multiplier result, sampled when FMULDone=1
- FMULWA3  in  ADDR_W  destination register, sampled when FMULDone=1
- PipeRegWrite  in  1  main pipeline owns the register-file write port this cycle
- RA1  in  ADDR_W  decode read address 1
- RA2  in  ADDR_W  decode read address 2
- QWE3  out  1  register-file write enable from queue
- QWA3  out  ADDR_W  register-file write address from queue
- QWD3  out  DATA_W  register-file write data from queue
- Hazard1  out  1  RA1 has a pending FMUL write
- Hazard2  out  1  RA2 has a pending FMUL write
- Full  out  1  Count == DEPTH
- Empty  out  1  Count == 0
- Count  out  $clog2(DEPTH+1)  occupied entries
- Overflow  out  1  sticky; a result was dropped

## Operation
- Storage: DEPTH entries of {valid, addr, data}. Write pointer and read pointer are log2(DEPTH) bits and wrap modulo DEPTH. Count is kept separately.
- Push: when FMULDone=1 and (Full=0, or a pop occurs in the same cycle), write {FMULWA3, FMULResult} at the write pointer, then increment the write pointer.
- Drop: when FMULDone=1, Full=1 and there is no pop, discard the entry and set Overflow=1. Overflow stays set until Reset.
- Pop: QWE3 = !Empty & !PipeRegWrite. QWA3 and QWD3 always present the head entry; their values are don't-care when Empty. When QWE3=1, the head is consumed at the edge, the read pointer increments, and the valid bit clears.
- PipeRegWrite always has priority. The queue never writes in a cycle the pipeline writes.
- No bypass: a result pushed in cycle N can be written to the register file no earlier than cycle N+1.
- Ordering: strict FIFO. Two queued writes to the same address retire in arrival order, so the last write wins.
- Hazard1 is 1 when any valid entry has addr==RA1, or when FMULDone=1 and FMULWA3==RA1. Hazard2 is defined the same way for RA2.
- An entry being popped this cycle still counts for hazards. The hazard clears in the following cycle.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop: unchanged
  - drop: unchanged
- Full, Empty and QWE3 are combinational from registered state plus PipeRegWrite.

## Timing
- Reset (async, immediate): pointers=0, Count=0, all valid=0, Overflow=0.
- Outputs during reset: QWE3=0, Empty=1, Full=0, Hazard1/2 depend only on FMULDone/FMULWA3 (no valid entries).
- Reset asserted mid-operation: all queued results are lost. No register-file write occurs while Reset=1.
- Latency: FMULDone in cycle N with an empty queue and PipeRegWrite=0 in N+1 gives QWE3=1 in N+1. The write commits at the end of N+1.
- Throughput: one push and one pop per cycle.
- Simultaneous push+pop when Full: accepted, no Overflow, Count stays DEPTH.
- Simultaneous push+pop when Empty: impossible, because pop requires !Empty. The push lands and is written next cycle.
- Pointer wrap: after DEPTH pushes the write pointer returns to 0 with no side effect.

## Test plan
- Single result: Reset, then FMULDone=1 with WA3=5, Result=0x40490FDB, PipeRegWrite=0 → next cycle QWE3=1, QWA3=5, QWD3=0x40490FDB. The cycle after: Empty=1, QWE3=0.
- Port contention: push WA3=2 while PipeRegWrite held 1 for 3 cycles → QWE3=0 throughout, Hazard1=1 for RA1=2. Write occurs in the first cycle with PipeRegWrite=0, and Hazard1=0 the cycle after.
- Fill and overflow: DEPTH=4, PipeRegWrite=1, 5 pushes with WA3=1..5 → Full=1 after the 4th, Overflow=1 after the 5th. Release → writes 1,2,3,4 in order, entry 5 never written, Overflow remains 1.
- Full with push+pop: queue full, PipeRegWrite=0, FMULDone=1 WA3=9 → no Overflow, Count=4. Entry 9 is retired last.
- Same-address ordering and wrap: 6 pushes to WA3=7 with data 1..6, interleaved so the pointers wrap → QWD3 sequence 1..6. Hazard1 (RA1=7) drops only after the 6th write.
- Async reset mid-drain: 3 entries queued, assert Reset between clock edges → QWE3=0, Empty=1, Count=0 immediately. No writes after deassertion.

Source files
------------

// File: rtl/fmul_wb_queue.sv
// In-order FMUL writeback FIFO; a result captured in cycle N can retire from N+1 on.
// Retires only when the pipeline leaves the write port free; drops into sticky Overflow when full.
module fmul_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              FMULDone,
  input  logic [DATA_W-1:0] FMULResult,
  input  logic [ADDR_W-1:0] FMULWA3,
  input  logic              PipeRegWrite,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  output logic              QWE3,
  output logic [ADDR_W-1:0] QWA3,
  output logic [DATA_W-1:0] QWD3,
  output logic              Hazard1,
  output logic              Hazard2,
  output logic              Full,
  output logic              Empty,
  output logic [CW-1:0]     Count,
  output logic              Overflow
);

  logic              valid_q [DEPTH];
  logic              valid_d [DEPTH];
  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [ADDR_W-1:0] addr_d  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;

  logic empty, full, pop, push, drop;

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CW'(DEPTH));
    pop   = !empty && !PipeRegWrite;
    // A pop frees the head slot in the same edge, so a full queue still accepts.
    push  = FMULDone && (!full || pop);
    drop  = FMULDone && full && !pop;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i];
      addr_d[i]  = addr_q[i];
      data_d[i]  = data_q[i];
    end
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;

    // Pop before push: when full, both pointers address the same slot.
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      addr_d[wr_ptr_q]  = FMULWA3;
      data_d[wr_ptr_q]  = FMULResult;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= valid_d[i];
        addr_q[i]  <= addr_d[i];
        data_q[i]  <= data_d[i];
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // The entry being popped and the result arriving this cycle both still block readers.
  always_comb begin
    Hazard1 = FMULDone && (FMULWA3 == RA1);
    Hazard2 = FMULDone && (FMULWA3 == RA2);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == RA1)) Hazard1 = 1'b1;
      if (valid_q[i] && (addr_q[i] == RA2)) Hazard2 = 1'b1;
    end
  end

  always_comb begin
    QWE3     = pop;
    QWA3     = addr_q[rd_ptr_q];
    QWD3     = data_q[rd_ptr_q];
    Full     = full;
    Empty    = empty;
    Count    = count_q;
    Overflow = overflow_q;
  end

endmodule

// File: tb/tb_fmul_wb_queue.sv
// Bench for fmul_wb_queue: directed vector table, corner sequences, and random traffic vs a queue model.
module tb_fmul_wb_queue;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        FMULDone = 1'b0;
  logic [31:0] FMULResult = '0;
  logic [3:0]  FMULWA3 = '0;
  logic        PipeRegWrite = 1'b0;
  logic [3:0]  RA1 = '0;
  logic [3:0]  RA2 = '0;
  logic        QWE3;
  logic [3:0]  QWA3;
  logic [31:0] QWD3;
  logic        Hazard1, Hazard2, Full, Empty, Overflow;
  logic [2:0]  Count;

  fmul_wb_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(4)) dut (
    .CLK(CLK), .Reset(Reset), .FMULDone(FMULDone), .FMULResult(FMULResult),
    .FMULWA3(FMULWA3), .PipeRegWrite(PipeRegWrite), .RA1(RA1), .RA2(RA2),
    .QWE3(QWE3), .QWA3(QWA3), .QWD3(QWD3), .Hazard1(Hazard1), .Hazard2(Hazard2),
    .Full(Full), .Empty(Empty), .Count(Count), .Overflow(Overflow)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        done;
    logic [3:0]  wa;
    logic [31:0] res;
    logic        prw;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic        qwe;
    logic [3:0]  qwa;
    logic [31:0] qwd;
    logic        h1;
    logic        h2;
    logic [2:0]  cnt;
    logic        ovf;
  } vec_t;

  function automatic vec_t mk(input logic d, input logic [3:0] wa, input logic [31:0] r,
                              input logic p, input logic [3:0] a1, input logic [3:0] a2,
                              input logic qwe, input logic [3:0] qwa, input logic [31:0] qwd,
                              input logic h1, input logic h2, input logic [2:0] cnt,
                              input logic ovf);
    vec_t v;
    v.done = d; v.wa = wa; v.res = r; v.prw = p; v.ra1 = a1; v.ra2 = a2;
    v.qwe = qwe; v.qwa = qwa; v.qwd = qwd; v.h1 = h1; v.h2 = h2; v.cnt = cnt; v.ovf = ovf;
    return v;
  endfunction

  // Reference model: plain FIFO of {addr,data} plus sticky overflow flag.
  logic [35:0] mq[$];
  logic        m_ovf;
  logic [35:0] wr_log[$];

  task automatic drive(input logic d, input logic [3:0] wa, input logic [31:0] r,
                       input logic p, input logic [3:0] a1, input logic [3:0] a2);
    FMULDone = d; FMULWA3 = wa; FMULResult = r; PipeRegWrite = p; RA1 = a1; RA2 = a2;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    wr_log.delete();
  endtask

  task automatic step(input logic d, input logic [3:0] wa, input logic [31:0] r,
                      input logic p, input logic [3:0] a1, input logic [3:0] a2);
    logic e_qwe, e_h1, e_h2, e_full;
    int   sz;
    @(negedge CLK);
    drive(d, wa, r, p, a1, a2);
    #1;
    sz     = mq.size();
    e_full = (sz == DEPTH);
    e_qwe  = (sz != 0) && !p;
    e_h1   = d && (wa == a1);
    e_h2   = d && (wa == a2);
    foreach (mq[i]) begin
      if (mq[i][35:32] == a1) e_h1 = 1'b1;
      if (mq[i][35:32] == a2) e_h2 = 1'b1;
    end
    chk("qwe3", QWE3, e_qwe);
    if (sz != 0) begin
      chk("qwa3_head", QWA3, mq[0][35:32]);
      chk("qwd3_head", QWD3, mq[0][31:0]);
    end
    chk("hazard1", Hazard1, e_h1);
    chk("hazard2", Hazard2, e_h2);
    chk("count", Count, sz);
    chk("empty", Empty, sz == 0);
    chk("full", Full, e_full);
    chk("overflow", Overflow, m_ovf);
    if (QWE3 === 1'b1) wr_log.push_back({QWA3, QWD3});
    if (e_qwe) void'(mq.pop_front());
    if (d) begin
      if (!e_full || e_qwe) mq.push_back({wa, r});
      else m_ovf = 1'b1;
    end
  endtask

  initial begin
    vec_t vt[$];
    m_ovf = 1'b0;

    // Reset state, sampled while Reset is still asserted.
    #2;
    drive(1'b1, 4'd6, 32'h1234, 1'b0, 4'd6, 4'd3);
    #1;
    chk("rst_qwe3", QWE3, 1'b0);
    chk("rst_empty", Empty, 1'b1);
    chk("rst_full", Full, 1'b0);
    chk("rst_count", Count, 3'd0);
    chk("rst_overflow", Overflow, 1'b0);
    chk("rst_hazard1_done", Hazard1, 1'b1);
    chk("rst_hazard2", Hazard2, 1'b0);
    do_reset();

    // done wa res prw ra1 ra2 | qwe qwa qwd h1 h2 cnt ovf
    vt.push_back(mk(1, 5, 32'h40490FDB, 0, 5, 0,  0, 0, 0,            1, 0, 0, 0));
    vt.push_back(mk(0, 0, 0,            0, 5, 0,  1, 5, 32'h40490FDB, 1, 0, 1, 0));
    vt.push_back(mk(0, 0, 0,            0, 5, 0,  0, 0, 0,            0, 0, 0, 0));
    vt.push_back(mk(1, 2, 32'h22,       1, 2, 0,  0, 0, 0,            1, 0, 0, 0));
    vt.push_back(mk(0, 0, 0,            1, 2, 0,  0, 0, 0,            1, 0, 1, 0));
    vt.push_back(mk(0, 0, 0,            1, 2, 0,  0, 0, 0,            1, 0, 1, 0));
    vt.push_back(mk(0, 0, 0,            0, 2, 0,  1, 2, 32'h22,       1, 0, 1, 0));
    vt.push_back(mk(0, 0, 0,            0, 2, 0,  0, 0, 0,            0, 0, 0, 0));
    vt.push_back(mk(1, 1, 32'h101,      1, 1, 4,  0, 0, 0,            1, 0, 0, 0));
    vt.push_back(mk(1, 2, 32'h102,      1, 1, 4,  0, 0, 0,            1, 0, 1, 0));
    vt.push_back(mk(1, 3, 32'h103,      1, 1, 4,  0, 0, 0,            1, 0, 2, 0));
    vt.push_back(mk(1, 4, 32'h104,      1, 1, 4,  0, 0, 0,            1, 1, 3, 0));
    vt.push_back(mk(1, 5, 32'h105,      1, 1, 4,  0, 0, 0,            1, 1, 4, 0));
    vt.push_back(mk(0, 0, 0,            1, 1, 4,  0, 0, 0,            1, 1, 4, 1));
    vt.push_back(mk(0, 0, 0,            0, 1, 4,  1, 1, 32'h101,      1, 1, 4, 1));
    vt.push_back(mk(0, 0, 0,            0, 1, 4,  1, 2, 32'h102,      0, 1, 3, 1));
    vt.push_back(mk(0, 0, 0,            0, 1, 4,  1, 3, 32'h103,      0, 1, 2, 1));
    vt.push_back(mk(0, 0, 0,            0, 1, 4,  1, 4, 32'h104,      0, 1, 1, 1));
    vt.push_back(mk(0, 0, 0,            0, 1, 5,  0, 0, 0,            0, 0, 0, 1));

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge CLK);
      drive(vt[i].done, vt[i].wa, vt[i].res, vt[i].prw, vt[i].ra1, vt[i].ra2);
      #1;
      chk($sformatf("vec%0d_qwe3", i), QWE3, vt[i].qwe);
      if (vt[i].qwe) begin
        chk($sformatf("vec%0d_qwa3", i), QWA3, vt[i].qwa);
        chk($sformatf("vec%0d_qwd3", i), QWD3, vt[i].qwd);
      end
      chk($sformatf("vec%0d_hazard1", i), Hazard1, vt[i].h1);
      chk($sformatf("vec%0d_hazard2", i), Hazard2, vt[i].h2);
      chk($sformatf("vec%0d_count", i), Count, vt[i].cnt);
      chk($sformatf("vec%0d_empty", i), Empty, vt[i].cnt == 3'd0);
      chk($sformatf("vec%0d_full", i), Full, vt[i].cnt == 3'd4);
      chk($sformatf("vec%0d_overflow", i), Overflow, vt[i].ovf);
    end

    // Full queue with simultaneous push and pop: accepted, entry 9 retires last.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 4'(10 + i), 32'(16 + i), 1'b1, 4'd9, 4'd0);
    step(1'b1, 4'd9, 32'h99, 1'b0, 4'd9, 4'd0);
    chk("fullpp_overflow", Overflow, 1'b0);
    chk("fullpp_count", Count, 3'd4);
    for (int i = 0; i < 5; i++) step(1'b0, 4'd0, 32'd0, 1'b0, 4'd9, 4'd0);
    chk("fullpp_nwrites", wr_log.size(), 5);
    if (wr_log.size() == 5) chk("fullpp_last", wr_log[4], {4'd9, 32'h99});

    // Same-address writes through a pointer wrap keep arrival order.
    do_reset();
    for (int i = 1; i <= 3; i++) step(1'b1, 4'd7, 32'(i), 1'b1, 4'd7, 4'd0);
    for (int i = 4; i <= 6; i++) step(1'b1, 4'd7, 32'(i), 1'b0, 4'd7, 4'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 32'd0, 1'b0, 4'd7, 4'd0);
    chk("same_addr_hazard_clear", Hazard1, 1'b0);
    chk("same_addr_nwrites", wr_log.size(), 6);
    foreach (wr_log[i]) chk($sformatf("same_addr_order%0d", i), wr_log[i], {4'd7, 32'(i + 1)});

    // Asynchronous reset mid-drain.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 4'(3 + i), 32'(40 + i), 1'b1, 4'd0, 4'd0);
    @(negedge CLK);
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd3, 4'd4);
    #2;
    chk("arst_pre_qwe3", QWE3, 1'b1);
    Reset = 1'b1;
    #1;
    chk("arst_qwe3", QWE3, 1'b0);
    chk("arst_empty", Empty, 1'b1);
    chk("arst_count", Count, 3'd0);
    chk("arst_hazard1", Hazard1, 1'b0);
    @(posedge CLK);
    #1;
    chk("arst_held_qwe3", QWE3, 1'b0);
    @(negedge CLK);
    Reset = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    wr_log.delete();
    for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 32'd0, 1'b0, 4'd3, 4'd4);
    chk("arst_no_writes", wr_log.size(), 0);

    // Random traffic against the model; narrow address range to exercise hazards.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) < 55), 4'($urandom_range(0, 5)), $urandom,
           ($urandom_range(0, 99) < 45), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
